// File: rtl/mem_access.sv
// MEM pipeline stage: drives a ready/ack data memory for loads and stores
// and registers the MEM/WB result bundle.
module mem_access #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [5:0]  ex_opcode,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [3:0]  ex_we,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_wb_valid,
    output logic [31:0] mem_wb_data,
    output logic [4:0]  mem_wb_rd,
    output logic        mem_wb_reg_write,
    output logic [1:0]  mem_exc
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LBU = 6'd11;
    localparam logic [5:0] OP_LH  = 6'd12;
    localparam logic [5:0] OP_LHU = 6'd13;
    localparam logic [5:0] OP_LW  = 6'd14;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [5:0]    op_q, op_d;
    logic [1:0]    lane_q, lane_d;
    logic [4:0]    rd_q, rd_d;
    logic          rw_q, rw_d;
    logic          wbv_q, wbv_d;
    logic [31:0]   wbdata_q, wbdata_d;
    logic [4:0]    wbrd_q, wbrd_d;
    logic          wbrw_q, wbrw_d;
    logic [1:0]    exc_q, exc_d;

    logic        is_load, is_store, is_half, is_word, misal;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign is_load  = ex_opcode inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    assign is_store = ex_opcode inside {OP_SB, OP_SH, OP_SW};
    assign is_half  = ex_opcode inside {OP_LH, OP_LHU, OP_SH};
    assign is_word  = ex_opcode inside {OP_LW, OP_SW};
    assign misal    = (is_half && ex_addr[0]) || (is_word && ex_addr[1:0] != 2'b00);

    always_comb begin
        st_data = ex_store_data;
        if (ex_opcode == OP_SB) st_data = {4{ex_store_data[7:0]}};
        if (ex_opcode == OP_SH) st_data = {2{ex_store_data[15:0]}};
    end

    // Lane extraction uses the byte offset captured at acceptance
    always_comb begin
        ld_byte = 8'(dmem_rdata >> {lane_q, 3'b000});
        ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'd0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'd0, ld_half};
            default: ld_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        op_d     = op_q;
        lane_d   = lane_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        wbv_d    = 1'b0;
        wbdata_d = wbdata_q;
        wbrd_d   = wbrd_q;
        wbrw_d   = wbrw_q;
        exc_d    = exc_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (!(is_load || is_store)) begin
                        wbv_d    = 1'b1;
                        wbdata_d = ex_store_data;
                        wbrd_d   = ex_rd;
                        wbrw_d   = ex_reg_write;
                        exc_d    = 2'b00;
                    end else if (misal) begin
                        wbv_d    = 1'b1;
                        wbdata_d = ex_addr;
                        wbrd_d   = ex_rd;
                        wbrw_d   = 1'b0;
                        exc_d    = 2'b01;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        addr_d  = {ex_addr[31:2], 2'b00};
                        we_d    = is_load ? 4'b0000 : ex_we;
                        wdata_d = st_data;
                        op_d    = ex_opcode;
                        lane_d  = ex_addr[1:0];
                        rd_d    = ex_rd;
                        rw_d    = is_load && ex_reg_write;
                    end
                end
            end
            default: begin
                if (dmem_ack) begin
                    state_d  = S_IDLE;
                    req_d    = 1'b0;
                    cnt_d    = '0;
                    wbv_d    = 1'b1;
                    wbdata_d = ld_val;
                    wbrd_d   = rd_q;
                    wbrw_d   = rw_q;
                    exc_d    = 2'b00;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_IDLE;
                    req_d    = 1'b0;
                    cnt_d    = '0;
                    wbv_d    = 1'b1;
                    wbrd_d   = rd_q;
                    wbrw_d   = 1'b0;
                    exc_d    = 2'b10;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= '0;
            wdata_q  <= '0;
            op_q     <= '0;
            lane_q   <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            wbv_q    <= 1'b0;
            wbdata_q <= '0;
            wbrd_q   <= '0;
            wbrw_q   <= 1'b0;
            exc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            wbv_q    <= wbv_d;
            wbdata_q <= wbdata_d;
            wbrd_q   <= wbrd_d;
            wbrw_q   <= wbrw_d;
            exc_q    <= exc_d;
        end
    end

    assign ex_ready         = (state_q == S_IDLE);
    assign dmem_req         = req_q;
    assign dmem_addr        = addr_q;
    assign dmem_we          = we_q;
    assign dmem_wdata       = wdata_q;
    assign mem_wb_valid     = wbv_q;
    assign mem_wb_data      = wbdata_q;
    assign mem_wb_rd        = wbrd_q;
    assign mem_wb_reg_write = wbrw_q;
    assign mem_exc          = exc_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected MEM/WB bundles are queued at
// issue and compared whenever the stage emits a valid pulse.
module tb_mem_access;

    localparam logic [5:0] OP_ALU = 6'd1;
    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LBU = 6'd11;
    localparam logic [5:0] OP_LH  = 6'd12;
    localparam logic [5:0] OP_LHU = 6'd13;
    localparam logic [5:0] OP_LW  = 6'd14;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  exc;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [3:0]  ex_we;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_wb_valid;
    logic [31:0] mem_wb_data;
    logic [4:0]  mem_wb_rd;
    logic        mem_wb_reg_write;
    logic [1:0]  mem_exc;

    int  checks = 0;
    int  errors = 0;
    wb_t sb[$];
    wb_t e;

    mem_access #(.ACK_TIMEOUT(4)) dut (
        .clk(clk),
        .rst(rst),
        .ex_valid(ex_valid),
        .ex_ready(ex_ready),
        .ex_opcode(ex_opcode),
        .ex_addr(ex_addr),
        .ex_store_data(ex_store_data),
        .ex_we(ex_we),
        .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req),
        .dmem_addr(dmem_addr),
        .dmem_we(dmem_we),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .mem_wb_valid(mem_wb_valid),
        .mem_wb_data(mem_wb_data),
        .mem_wb_rd(mem_wb_rd),
        .mem_wb_reg_write(mem_wb_reg_write),
        .mem_exc(mem_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic wb_t model(input logic [5:0] op, input logic [31:0] a,
                                  input logic [31:0] d, input logic [4:0] rd,
                                  input logic rw, input logic [31:0] rdata);
        wb_t r;
        logic [7:0] b;
        logic [15:0] h;
        b = rdata[a[1:0]*8 +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        r.data = d;
        r.rd = rd;
        r.rw = rw;
        r.exc = 2'b00;
        case (op)
            OP_LB:  r.data = {{24{b[7]}}, b};
            OP_LBU: r.data = {24'd0, b};
            OP_LH:  r.data = {{16{h[15]}}, h};
            OP_LHU: r.data = {16'd0, h};
            OP_LW:  r.data = rdata;
            OP_SB, OP_SH, OP_SW: r.rw = 1'b0;
            default: ;
        endcase
        if (((op == OP_LH || op == OP_LHU || op == OP_SH) && a[0]) ||
            ((op == OP_LW || op == OP_SW) && a[1:0] != 2'b00)) begin
            r.rw = 1'b0;
            r.exc = 2'b01;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (mem_wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wb_rd", mem_wb_rd, e.rd);
                chk("wb_reg_write", mem_wb_reg_write, e.rw);
                chk("wb_exc", mem_exc, e.exc);
                if (e.rw) chk("wb_data", mem_wb_data, e.data);
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] we,
                         input logic [4:0] rd, input logic rw,
                         input logic [31:0] rdata, input bit push);
        chk("ex_ready", ex_ready, 1);
        ex_valid = 1'b1;
        ex_opcode = op;
        ex_addr = a;
        ex_store_data = d;
        ex_we = we;
        ex_rd = rd;
        ex_reg_write = rw;
        if (push) sb.push_back(model(op, a, d, rd, rw, rdata));
        @(negedge clk);
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        ex_opcode = 6'd0;
    endtask

    task automatic mem(input string tag, input int dly, input logic [31:0] rdata,
                       input logic [31:0] ea, input logic [3:0] ewe,
                       input logic [31:0] ewd);
        int n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_addr"}, dmem_addr, ea);
        chk({tag, "_we"}, dmem_we, ewe);
        if (ewe != 4'b0000) chk({tag, "_wdata"}, dmem_wdata, ewd);
        for (int i = 0; i < dly; i++) begin
            chk({tag, "_ready_low"}, ex_ready, 0);
            @(negedge clk);
            chk({tag, "_req_held"}, dmem_req, 1);
            chk({tag, "_addr_held"}, dmem_addr, ea);
        end
        chk({tag, "_ready_low"}, ex_ready, 0);
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_ack = 1'b0;
        dmem_rdata = $urandom;
        chk({tag, "_req_drop"}, dmem_req, 0);
        chk({tag, "_ready_back"}, ex_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        wb_t t;
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        idle();
        ex_addr = 0;
        ex_store_data = 0;
        ex_we = 0;
        ex_rd = 0;
        ex_reg_write = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ex_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_valid", mem_wb_valid, 0);
        chk("rst_data", mem_wb_data, 0);
        chk("rst_exc", mem_exc, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_ALU, 32'h0, 32'h0000_1234, 4'b0000, 5'd5, 1'b1, 0, 1);
        idle();
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++)
            issue(OP_ALU, 32'h0, 32'h1111_0000 + i, 4'b0000, 5'(i + 8), i[0], 0, 1);
        idle();
        repeat (2) @(negedge clk);

        issue(OP_SB, 32'h103, 32'h0000_00AB, 4'b1000, 5'd3, 1'b1, 0, 1);
        idle();
        mem("sb", 3, 32'h0, 32'h100, 4'b1000, 32'hABAB_ABAB);
        repeat (2) @(negedge clk);

        issue(OP_LB, 32'h102, 0, 4'b0000, 5'd7, 1'b1, 32'h0080_0000, 1);
        idle();
        mem("lb", 0, 32'h0080_0000, 32'h100, 4'b0000, 0);
        issue(OP_LBU, 32'h102, 0, 4'b0000, 5'd8, 1'b1, 32'h0080_0000, 1);
        idle();
        mem("lbu", 1, 32'h0080_0000, 32'h100, 4'b0000, 0);
        issue(OP_LH, 32'h102, 0, 4'b0000, 5'd9, 1'b1, 32'h8001_0000, 1);
        idle();
        mem("lh", 0, 32'h8001_0000, 32'h100, 4'b0000, 0);
        issue(OP_LHU, 32'h200, 0, 4'b0000, 5'd10, 1'b1, 32'h1234_8765, 1);
        idle();
        mem("lhu", 2, 32'h1234_8765, 32'h200, 4'b0000, 0);
        issue(OP_LW, 32'h304, 0, 4'b0000, 5'd11, 1'b1, 32'hDEAD_BEEF, 1);
        idle();
        mem("lw", 0, 32'hDEAD_BEEF, 32'h304, 4'b0000, 0);
        issue(OP_SH, 32'h402, 32'h0000_5A3C, 4'b1100, 5'd12, 1'b0, 0, 1);
        idle();
        mem("sh", 1, 32'h0, 32'h400, 4'b1100, 32'h5A3C_5A3C);
        issue(OP_SW, 32'h500, 32'hCAFE_F00D, 4'b1111, 5'd13, 1'b0, 0, 1);
        idle();
        mem("sw", 0, 32'h0, 32'h500, 4'b1111, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);

        issue(OP_SH, 32'h101, 32'h1, 4'b0000, 5'd14, 1'b0, 0, 1);
        idle();
        chk("mis_sh_noreq", dmem_req, 0);
        issue(OP_LW, 32'h102, 0, 4'b0000, 5'd15, 1'b1, 0, 1);
        idle();
        chk("mis_lw_noreq", dmem_req, 0);
        repeat (2) @(negedge clk);

        t = '{data: 32'h0, rd: 5'd16, rw: 1'b0, exc: 2'b10};
        sb.push_back(t);
        issue(OP_LW, 32'h600, 0, 4'b0000, 5'd16, 1'b1, 0, 0);
        idle();
        n = 0;
        while (dmem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", n, 4);
        repeat (2) @(negedge clk);

        issue(OP_LW, 32'h700, 0, 4'b0000, 5'd17, 1'b1, 32'h0BAD_F00D, 1);
        idle();
        mem("lw_late", 3, 32'h0BAD_F00D, 32'h700, 4'b0000, 0);
        repeat (2) @(negedge clk);

        issue(OP_LW, 32'h800, 0, 4'b0000, 5'd18, 1'b1, 0, 0);
        idle();
        chk("rst_acc_req1", dmem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_acc_req0", dmem_req, 0);
        chk("rst_acc_valid0", mem_wb_valid, 0);
        issue(OP_ALU, 32'h0, 32'h7777_0001, 4'b0000, 5'd19, 1'b1, 0, 1);
        idle();
        repeat (4) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
